mul_ctrl: RTL and testbench

Sequencing controller between the execute stage and the iterative 32x32 unsigned shift-add multiplier. It decodes the four RV32M multiply ops, converts signed operands to magnitudes, and holds the multiplier request for the whole computation. It then sign-corrects the 64-bit product, selects the low or high word, and returns it with a one-cycle done pulse while stalling the pipeline.

---
 rtl/mul_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mul_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_ctrl
// Purpose  : Sequencing controller between the execute stage and an iterative
//            unsigned multiplier. Decodes RV32M MUL/MULH/MULHSU/MULHU, hands
//            operand magnitudes to the multiplier, sign-corrects the 64-bit
//            product and returns the selected word with a one-cycle done
//            pulse while stalling the pipeline.
// Ports    : clk_i, rst_i (async, active-high)
//            valid_i, op_i[1:0], rs1_i, rs2_i, flush_i  - request from execute
//            ready_o, stall_o, done_o, rd_o              - response to execute
//            mul_req_o, mul_a_o, mul_b_o                 - request to multiplier
//            mul_ready_i, mul_result_i                   - multiplier response
// Options  : MUL_RESULT_CACHE_EN - one-entry result cache; a hit skips the
//            multiplier and completes one cycle after accept.
// Revision : 1.0 - initial release
// ============================================================================
module mul_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rd_o,
  output logic              mul_req_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  input  logic              mul_ready_i,
  input  logic [2*XLEN-1:0] mul_result_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  localparam logic [XLEN-1:0]   ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_P = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [2*XLEN-1:0] prod_q;

  logic              accept;
  logic              cls_a;      // rs1 treated as signed by this op
  logic              cls_b;      // rs2 treated as signed by this op
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   word_fix;
  logic              hit;
  logic [XLEN-1:0]   hit_word;

  // Flush has priority over a new request in the same cycle.
  assign accept = (state == S_IDLE) && valid_i && !flush_i;

  assign cls_a = (op_i == OP_MULH) || (op_i == OP_MULHSU);
  assign cls_b = (op_i == OP_MULH);
  assign sa    = cls_a && rs1_i[XLEN-1];
  assign sb    = cls_b && rs2_i[XLEN-1];

  // Two's-complement negation of the most negative value wraps to itself,
  // which is exactly its unsigned magnitude.
  assign mag_a = sa ? (~rs1_i + ONE_X) : rs1_i;
  assign mag_b = sb ? (~rs2_i + ONE_X) : rs2_i;

  assign prod_fix = neg_q ? (~prod_q + ONE_P) : prod_q;
  // The low word is sign-independent, so MUL never needs a separate path.
  assign word_fix = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef MUL_RESULT_CACHE_EN
  logic              c_valid;
  logic [XLEN-1:0]   c_rs1;
  logic [XLEN-1:0]   c_rs2;
  logic              c_sa;
  logic              c_sb;
  logic [2*XLEN-1:0] c_prod;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic              cls_a_q;
  logic              cls_b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_valid <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_sa    <= 1'b0;
      c_sb    <= 1'b0;
      c_prod  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      cls_a_q <= 1'b0;
      cls_b_q <= 1'b0;
    end else begin
      if (accept) begin
        rs1_q   <= rs1_i;
        rs2_q   <= rs2_i;
        cls_a_q <= cls_a;
        cls_b_q <= cls_b;
      end
      // Only products that actually completed are remembered; a flush
      // leaves any older entry intact.
      if ((state == S_FIX) && !flush_i) begin
        c_valid <= 1'b1;
        c_rs1   <= rs1_q;
        c_rs2   <= rs2_q;
        c_sa    <= cls_a_q;
        c_sb    <= cls_b_q;
        c_prod  <= prod_fix;
      end
    end
  end

  // MUL can reuse any entry with matching operands: its low word does not
  // depend on how the operands were interpreted.
  assign hit = c_valid && (rs1_i == c_rs1) && (rs2_i == c_rs2) &&
               ((op_i == OP_MUL) || ((cls_a == c_sa) && (cls_b == c_sb)));
  assign hit_word = (op_i == OP_MUL) ? c_prod[XLEN-1:0] : c_prod[2*XLEN-1:XLEN];
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      rd_o    <= '0;
      mul_a_o <= '0;
      mul_b_o <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            op_q    <= op_i;
            neg_q   <= sa ^ sb;
            mul_a_o <= mag_a;
            mul_b_o <= mag_b;
            if (hit) begin
              rd_o  <= hit_word;
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mul_ready_i) begin
            prod_q <= mul_result_i;
            state  <= S_FIX;
          end
        end
        S_FIX: begin
          rd_o  <= word_fix;
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o   = (state == S_IDLE);
  // Request is held only while waiting, which also guarantees a low gap
  // between consecutive operations.
  assign mul_req_o = (state == S_WAIT);
  assign done_o    = (state == S_DONE) && !flush_i;
  assign stall_o   = !rst_i && ((state != S_IDLE) || accept);

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_ctrl
// Purpose  : Self-checking bench for mul_ctrl with a behavioural multiplier,
//            a scoreboard of expected rd values and a shadow cache model
//            (active when MUL_RESULT_CACHE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o, stall_o, done_o, mul_req_o;
  logic [31:0] rd_o, mul_a_o, mul_b_o;
  logic        mul_ready_i = 1'b0;
  logic [63:0] mul_result_i = '0;

  mul_ctrl #(.XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .op_i         (op_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .flush_i      (flush_i),
    .ready_o      (ready_o),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rd_o         (rd_o),
    .mul_req_o    (mul_req_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_ready_i  (mul_ready_i),
    .mul_result_i (mul_result_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  int          mul_lat = 4;
  int          ready_cyc = 0;
  int          used_lat = 0;
  bit          m_busy = 0;
  int          m_cnt = 0;
  logic [63:0] m_prod = '0;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      mul_ready_i = 1'b0;
      if (m_busy && !mul_req_o) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mul_ready_i  = 1'b1;
          mul_result_i = m_prod;
          ready_cyc    = cyc;
          m_busy       = 0;
        end
      end else if (mul_req_o) begin
        // zero operand takes the fast path
        used_lat = ((mul_a_o == 0) || (mul_b_o == 0)) ? 1 : mul_lat;
        m_prod   = {32'b0, mul_a_o} * {32'b0, mul_b_o};
        m_cnt    = used_lat;
        m_busy   = 1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_rd(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_mag(input bit signed_op, input logic [31:0] v);
    return (signed_op && v[31]) ? (32'd0 - v) : v;
  endfunction

  // shadow of the one-entry result cache
  bit          cm_v = 0;
  logic [31:0] cm_a, cm_b;
  bit          cm_sa, cm_sb;

  function automatic bit predict_hit(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MUL_RESULT_CACHE_EN
    bit ca, cb;
    ca = (op == 2'b01) || (op == 2'b10);
    cb = (op == 2'b01);
    return cm_v && (a == cm_a) && (b == cm_b) && ((op == 2'b00) || (ca == cm_sa && cb == cm_sb));
`else
    return 0;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] sb_q[$];

  always @(negedge clk_i) begin
    if (done_o) begin
      if (sb_q.size() == 0) check("done_unexpected", 1, 0);
      else check("rd", rd_o, sb_q.pop_front());
    end
  end

  // Tasks are entered and left at posedge+1.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
    int  acc;
    bit  hit, got, req_seen;
    check("ready_before_accept", ready_o, 1);
    hit     = predict_hit(op, a, b);
    valid_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    #1;
    check("stall_accept", stall_o, 1);
    sb_q.push_back(expv);
    acc = cyc;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    if (!hit) begin
      check("mag_a", mul_a_o, ref_mag(op == 2'b01 || op == 2'b10, a));
      check("mag_b", mul_b_o, ref_mag(op == 2'b01, b));
    end
    got      = 0;
    req_seen = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (mul_req_o) req_seen = 1;
      check("stall_busy", stall_o, 1);
      if (done_o) begin
        got = 1;
        if (hit) begin
          check("hit_latency", cyc - acc, 1);
          check("hit_no_req", req_seen, 0);
        end else begin
          check("latency", cyc - acc, used_lat + 3);
          check("done_after_ready", cyc - ready_cyc, 2);
        end
      end else begin
        @(posedge clk_i);
        #1;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    check("done_single_pulse", done_o, 0);
    check("ready_after_done", ready_o, 1);
    check("stall_after_done", stall_o, 0);
    if (!hit) begin
      cm_v  = 1;
      cm_a  = a;
      cm_b  = b;
      cm_sa = (op == 2'b01) || (op == 2'b10);
      cm_sb = (op == 2'b01);
    end
  endtask

  task automatic flush_test();
    logic [31:0] rd_before;
    bit          seen_done;
    mul_lat   = 12;
    rd_before = rd_o;
    valid_i   = 1'b1;
    op_i      = 2'b11;
    rs1_i     = 32'h1111_1111;
    rs2_i     = 32'h2222_2222;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i);
      #1;
    end
    check("req_before_flush", mul_req_o, 1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("flush_req_low", mul_req_o, 0);
    check("flush_ready", ready_o, 1);
    check("flush_rd_kept", rd_o, rd_before);
    seen_done = 0;
    repeat (15) begin
      if (done_o) seen_done = 1;
      @(posedge clk_i);
      #1;
    end
    check("flush_no_done", seen_done, 0);
    check("flush_rd_still_kept", rd_o, rd_before);
  endtask

  task automatic reset_midop_test();
    mul_lat = 10;
    valid_i = 1'b1;
    op_i    = 2'b11;
    rs1_i   = 32'hDEAD_BEEF;
    rs2_i   = 32'h0000_0123;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b1;
    #1;
    check("arst_req", mul_req_o, 0);
    check("arst_ready", ready_o, 1);
    check("arst_stall", stall_o, 0);
    check("arst_rd", rd_o, 0);
    check("arst_mul_a", mul_a_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cm_v  = 0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    check("rst_req", mul_req_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_mul_a", mul_a_o, 0);
    check("rst_mul_b", mul_b_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    mul_lat = 4;
    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    mul_lat = 6;
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op(2'b11, 32'h0, 32'h1234_5678, 32'h0);

    flush_test();
    mul_lat = 3;
    do_op(2'b00, 32'd3, 32'd4, 32'd12);

    mul_lat = 5;
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, ref_rd(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, ref_rd(2'b00, 32'h1234_5678, 32'h9ABC_DEF0));

    for (int k = 0; k < 10; k++) begin
      rop     = 2'($urandom_range(0, 3));
      ra      = $urandom;
      rb      = (k == 4) ? 32'h0 : $urandom;
      mul_lat = $urandom_range(1, 6);
      do_op(rop, ra, rb, ref_rd(rop, ra, rb));
    end

    reset_midop_test();
    mul_lat = 2;
    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, ref_rd(2'b00, 32'h1234_5678, 32'h9ABC_DEF0));

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
